// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM select path: scan state encoding and the
// channel-index width rule used by both this mux and the matching demux.
package tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tdm_state_e;

    // A lone channel still needs a 1-bit index so the port never collapses to zero width.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tdm_next_ch.sv
// Finds the lowest set mask bit above the current index (or from the bottom
// when from_start=1) and reports whether that bit is the highest one set.
module tdm_next_ch
    import tdm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    input  logic                from_start,
    output logic [SEL_W-1:0]    idx,
    output logic                found,
    output logic                last
);

    int nxt_i;

    always_comb begin
        nxt_i = 0;
        found = 1'b0;
        // Descending scan so the lowest qualifying bit is the one that sticks.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                nxt_i = i;
                found = 1'b1;
            end
        end
        last = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mask[i] && (i > nxt_i)) begin
                last = 1'b0;
            end
        end
        idx = SEL_W'(nxt_i);
    end

endmodule

// File: rtl/tdm_mux.sv
// Frame-snapshot time-division multiplexer: scans enabled channels in
// ascending order onto one lane under a valid/ready handshake.
module tdm_mux
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS-1:0]       ch_mask,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_start,
    output logic                      frame_end
);

    tdm_state_e                state_q, state_d;
    logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
    logic [CHANNELS-1:0]       mask_q, mask_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [WIDTH-1:0]          data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      start_q, start_d;
    logic                      end_q, end_d;

    logic [SEL_W-1:0] first_idx, next_idx;
    logic             first_found, first_last;
    logic             next_found, next_last;

    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] v,
                                              input logic [SEL_W-1:0]          k);
        return v[k*WIDTH +: WIDTH];
    endfunction

    // First channel of a new frame comes from the live mask being latched this cycle.
    tdm_next_ch #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_first (
        .mask       (ch_mask),
        .cur        ('0),
        .from_start (1'b1),
        .idx        (first_idx),
        .found      (first_found),
        .last       (first_last)
    );

    tdm_next_ch #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_next (
        .mask       (mask_q),
        .cur        (sel_q),
        .from_start (1'b0),
        .idx        (next_idx),
        .found      (next_found),
        .last       (next_last)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        start_d = start_q;
        end_d   = end_q;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                data_d  = '0;
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                snap_d = in;
                mask_d = ch_mask;
                if (first_found) begin
                    state_d = ST_SEND;
                    sel_d   = first_idx;
                    data_d  = pick(in, first_idx);
                    valid_d = 1'b1;
                    start_d = 1'b1;
                    end_d   = first_last;
                end else begin
                    state_d = en ? ST_LOAD : ST_IDLE;
                end
            end
            ST_SEND: begin
                if (valid_q && out_ready) begin
                    if (next_found) begin
                        sel_d   = next_idx;
                        data_d  = pick(snap_q, next_idx);
                        start_d = 1'b0;
                        end_d   = next_last;
                    end else begin
                        // Last beat accepted: en decides between another frame and rest.
                        state_d = en ? ST_LOAD : ST_IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        start_d = 1'b0;
                        end_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                start_d = 1'b0;
                end_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign out_data    = data_q;
    assign out_sel     = sel_q;
    assign out_valid   = valid_q;
    assign frame_start = start_q;
    assign frame_end   = end_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Scoreboard bench for tdm_mux: directed frames push expected beats, a
// negedge monitor pops and compares every accepted beat.
module tb_tdm_mux;

    localparam int WIDTH    = 1;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [CHANNELS-1:0]       ch_mask;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic                      frame_start;
    logic                      frame_end;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected beat: {sel, data, frame_start, frame_end}
    logic [5:0] exp_q[$];

    tdm_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in          (in_bus),
        .ch_mask     (ch_mask),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] m, input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                logic first, last;
                first = 1'b1;
                last  = 1'b1;
                for (int j = 0; j < k; j++)     if (m[j]) first = 1'b0;
                for (int j = k + 1; j < 8; j++) if (m[j]) last  = 1'b0;
                exp_q.push_back({3'(k), d[k], first, last});
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    check("beat", {26'd0, out_sel, out_data, frame_start, frame_end}, {26'd0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n     = 1'b0;
        en        = 1'b0;
        in_bus    = '0;
        ch_mask   = '0;
        out_ready = 1'b1;
        cyc(2);
        check("reset_outputs", {out_valid, out_sel, out_data, frame_start, frame_end}, 32'd0);
        rst_n = 1'b1;

        // Full mask, two frames back to back
        in_bus  = 8'hA5;
        ch_mask = 8'hFF;
        push_frame(8'hFF, 8'hA5);
        push_frame(8'hFF, 8'hA5);
        en = 1'b1;
        cyc(1);
        check("load_no_valid", out_valid, 1'b0);
        cyc(1);
        check("first_beat_latency", {out_valid, out_sel, frame_start}, {1'b1, 3'd0, 1'b1});
        cyc(7);
        check("sel7_frame_end", {out_valid, out_sel, frame_end}, {1'b1, 3'd7, 1'b1});
        cyc(1);
        check("frame_gap", {out_valid, out_data}, 2'b00);
        cyc(1);
        check("second_frame_start", {out_valid, out_sel, frame_start}, {1'b1, 3'd0, 1'b1});
        en = 1'b0;
        cyc(8);
        check("idle_after_frame", out_valid, 1'b0);
        cyc(3);
        check("stays_idle", out_valid, 1'b0);
        check("sel_holds", out_sel, 3'd7);

        // Sparse masks
        in_bus  = 8'h3C;
        ch_mask = 8'h48;
        push_frame(8'h48, 8'h3C);
        en = 1'b1;
        cyc(2);
        check("sparse_first_sel", out_sel, 3'd3);
        en = 1'b0;
        cyc(4);
        check("sparse_idle", out_valid, 1'b0);
        in_bus  = 8'h10;
        ch_mask = 8'h10;
        push_frame(8'h10, 8'h10);
        en = 1'b1;
        cyc(2);
        check("single_both_flags", {out_sel, frame_start, frame_end}, {3'd4, 1'b1, 1'b1});
        en = 1'b0;
        cyc(3);

        // Backpressure at sel 2 with live input toggling
        in_bus  = 8'h04;
        ch_mask = 8'hFF;
        push_frame(8'hFF, 8'h04);
        en = 1'b1;
        cyc(2);
        en = 1'b0;
        cyc(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_bus = ~in_bus;
            cyc(1);
            check("stall_hold", {out_valid, out_sel, out_data}, {1'b1, 3'd2, 1'b1});
        end
        out_ready = 1'b1;
        cyc(1);
        check("stall_release", out_sel, 3'd3);
        cyc(6);
        check("stall_frame_done", out_valid, 1'b0);

        // en dropped at sel 4
        in_bus  = 8'h5A;
        ch_mask = 8'hFF;
        push_frame(8'hFF, 8'h5A);
        en = 1'b1;
        cyc(6);
        check("en_drop_sel4", out_sel, 3'd4);
        en = 1'b0;
        cyc(4);
        check("en_drop_idle", out_valid, 1'b0);
        cyc(3);
        check("en_drop_no_load", out_valid, 1'b0);

        // Empty mask parks in LOAD, then a single channel appears
        ch_mask = 8'h00;
        en      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("empty_mask_no_valid", out_valid, 1'b0);
        end
        in_bus  = 8'h01;
        ch_mask = 8'h01;
        push_frame(8'h01, 8'h01);
        en = 1'b0;
        cyc(3);
        check("mask_recovery_done", out_valid, 1'b0);
        check("mask_recovery_beat", exp_q.size(), 32'd0);

        // Reset during sel 5
        in_bus  = 8'hFF;
        ch_mask = 8'hFF;
        for (int k = 0; k < 5; k++) exp_q.push_back({3'(k), 1'b1, (k == 0), 1'b0});
        en = 1'b1;
        cyc(7);
        check("pre_reset_sel5", {out_valid, out_sel}, {1'b1, 3'd5});
        rst_n     = 1'b0;
        out_ready = 1'b0;
        cyc(1);
        check("midframe_reset", {out_valid, out_sel, out_data, frame_start, frame_end}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ch_mask   = 8'h06;
        in_bus    = 8'h04;
        push_frame(8'h06, 8'h04);
        cyc(2);
        check("restart_lowest", {out_valid, out_sel, frame_start}, {1'b1, 3'd1, 1'b1});
        en = 1'b0;
        cyc(4);
        check("restart_idle", out_valid, 1'b0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
